// File: rtl/bsn_unloader.sv
// bsn_unloader
// Turns one packed vector of N_INPUTS sorted words (for example the flat output
// bus of a bitonic sorting network) into a flow-controlled word stream.
//
// Handshakes: both sides use strict valid/ready. A transfer happens on a rising
// edge where valid and ready are both high (and, on the output side, en is high).
// Once a producer raises valid, its payload must be held until that transfer.
// This block never drops out_valid or changes out_data/out_idx/out_last while a
// word is waiting for out_ready.
//
// Ports:
//   clk, rst   single clock, synchronous active-high reset
//   en         global enable; low freezes every register and forces in_ready low
//   data_in    packed vector, word k = data_in[k*DATA_WIDTH +: DATA_WIDTH]
//   dir        emission order captured with the vector (1: word 0 first)
//   in_valid / in_ready   vector handshake
//   out_data / out_idx / out_last / out_valid / out_ready   word stream
module bsn_unloader #(
  parameter  int DATA_WIDTH = 32,
  parameter  int N_INPUTS   = 8,
  localparam int IDX_W      = $clog2(N_INPUTS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic [DATA_WIDTH*N_INPUTS-1:0] data_in,
  input  logic                           dir,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [IDX_W-1:0]               out_idx,
  output logic                           out_last,
  output logic                           out_valid,
  input  logic                           out_ready
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);

  state_t                         state_q, state_d;
  logic [DATA_WIDTH*N_INPUTS-1:0] vec_q;
  logic                           dir_q;
  logic [IDX_W-1:0]               cnt, cnt_d;
  logic                           load;
  logic                           accept;
  logic                           xfer;

  // Outputs come straight from registers, so the last word of a vector is
  // still presented correctly in the cycle a new vector is being loaded.
  assign out_idx   = dir_q ? cnt : (LAST_IDX - cnt);
  assign out_data  = vec_q[out_idx*DATA_WIDTH +: DATA_WIDTH];
  assign out_last  = (cnt == LAST_IDX);
  assign out_valid = (state_q == EMIT);

  // The second term lets a new vector replace the current one in the same
  // cycle its final word leaves, so consecutive vectors stream without a gap.
  assign in_ready = en & ~rst & ((state_q == IDLE) | (out_last & out_ready));

  assign accept = in_valid & in_ready;
  assign xfer   = out_valid & out_ready & en;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt;
    load    = 1'b0;
    if (accept) begin
      load    = 1'b1;
      cnt_d   = '0;
      state_d = EMIT;
    end else if (xfer) begin
      // N_INPUTS is a power of two, so the counter wraps to 0 on the last word
      // and is already clean for the next vector.
      cnt_d = cnt + 1'b1;
      if (out_last) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt     <= '0;
      vec_q   <= '0;
      dir_q   <= 1'b1;
    end else if (en) begin
      state_q <= state_d;
      cnt     <= cnt_d;
      if (load) begin
        vec_q <= data_in;
        dir_q <= dir;
      end
    end
  end

endmodule

// File: tb/tb_bsn_unloader.sv
// Testbench for bsn_unloader. Every cycle the bench drives the inputs just
// after the rising edge and compares the outputs on the falling edge. The
// reference is a queue of the words still owed to the consumer. Each word
// holds {data, idx, last}. An accepted vector is expanded into that queue in
// emission order, and a completed output transfer pops the front entry.
module tb_bsn_unloader;

  localparam int DW = 32;
  localparam int N  = 8;
  localparam int IW = $clog2(N);
  localparam int VW = DW * N;
  localparam int EW = DW + IW + 1;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          en;
  logic [VW-1:0] data_in;
  logic          dir;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;

  bsn_unloader #(.DATA_WIDTH(DW), .N_INPUTS(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .data_in   (data_in),
    .dir       (dir),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver: one clock cycle, checks outputs and advances the reference
  task automatic step(input logic iv, input logic [VW-1:0] d, input logic di,
                      input logic e, input logic ordy, input logic r,
                      output logic acc);
    logic          exp_valid;
    logic          exp_ready;
    logic [EW-1:0] front;
    logic [EW-1:0] w;
    int            k;
    @(posedge clk);
    #1;
    in_valid  = iv;
    data_in   = d;
    dir       = di;
    en        = e;
    out_ready = ordy;
    rst       = r;
    @(negedge clk);
    exp_valid = (exp_q.size() > 0);
    exp_ready = e & ~r & ((exp_q.size() == 0) || ((exp_q.size() == 1) && ordy));
    check("in_ready", 64'(in_ready), 64'(exp_ready));
    check("out_valid", 64'(out_valid), 64'(exp_valid));
    if (exp_valid) begin
      front = exp_q[0];
      check("out_data", 64'(out_data), 64'(front[EW-1 -: DW]));
      check("out_idx", 64'(out_idx), 64'(front[IW:1]));
      check("out_last", 64'(out_last), 64'(front[0]));
    end
    acc = iv & exp_ready;
    // state after the coming rising edge
    if (r) begin
      exp_q.delete();
    end else if (e) begin
      if (exp_valid && ordy) void'(exp_q.pop_front());
      if (acc) begin
        for (int j = 0; j < N; j++) begin
          k = di ? j : (N - 1 - j);
          w = {d[k*DW +: DW], IW'(k), (j == N - 1)};
          exp_q.push_back(w);
        end
      end
    end
  endtask

  function automatic logic [VW-1:0] ramp_vec(input int base);
    logic [VW-1:0] v;
    for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'(base + k);
    return v;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int k = 0; k < N; k++) v[k*DW +: DW] = $urandom;
    return v;
  endfunction

  logic          acc;
  logic [VW-1:0] va;
  logic [VW-1:0] vb;
  logic [VW-1:0] pend_vec;
  logic          pend;
  logic          pend_dir;
  logic          e_r;
  int            n_acc;
  int            en_off;

  initial begin
    rst = 1'b1; en = 1'b1; data_in = '0; dir = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0;

    // reset then idle
    step(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b1, acc);
    step(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b1, acc);
    step(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0, acc);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_idx", 64'(out_idx), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);

    // ascending, then descending, of words 1..8
    va = ramp_vec(1);
    step(1'b1, va, 1'b1, 1'b1, 1'b1, 1'b0, acc);
    check("asc_accept", 64'(acc), 64'd1);
    for (int i = 0; i < N; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, acc);
    step(1'b1, va, 1'b0, 1'b1, 1'b1, 1'b0, acc);
    check("desc_accept", 64'(acc), 64'd1);
    for (int i = 0; i < N; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0, acc);

    // back-to-back: in_valid held high, second vector 9..16
    vb = ramp_vec(9);
    n_acc = 0;
    for (int i = 0; i < 40 && n_acc < 2; i++) begin
      step(1'b1, (n_acc == 0) ? va : vb, 1'b1, 1'b1, 1'b1, 1'b0, acc);
      if (acc) n_acc++;
    end
    check("b2b_accepts", 64'(n_acc), 64'd2);
    for (int i = 0; i < N + 2; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0, acc);
    check("b2b_drained", 64'(exp_q.size()), 64'd0);

    // random back-pressure and enable windows
    pend = 1'b0; pend_vec = '0; pend_dir = 1'b1; en_off = 0;
    for (int i = 0; i < 600; i++) begin
      if (!pend && ($urandom_range(0, 3) != 0)) begin
        pend     = 1'b1;
        pend_vec = rand_vec();
        pend_dir = 1'($urandom_range(0, 1));
      end
      if (en_off == 0 && (i == 20 || $urandom_range(0, 40) == 0)) en_off = 3;
      e_r = (en_off == 0);
      if (en_off > 0) en_off--;
      step(pend, pend_vec, pend_dir, e_r, 1'($urandom_range(0, 1)), 1'b0, acc);
      if (acc) pend = 1'b0;
    end
    for (int i = 0; i < 3 * N && exp_q.size() > 0; i++)
      step(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0, acc);
    check("rand_drained", 64'(exp_q.size()), 64'd0);

    // reset mid-stream after 3 words, then a fresh vector streams from its start
    step(1'b1, vb, 1'b0, 1'b1, 1'b1, 1'b0, acc);
    check("mid_accept", 64'(acc), 64'd1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0, acc);
    step(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b1, acc);
    step(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0, acc);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    step(1'b1, va, 1'b1, 1'b1, 1'b1, 1'b0, acc);
    check("post_rst_accept", 64'(acc), 64'd1);
    for (int i = 0; i < N + 1; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0, acc);
    check("post_rst_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
